bus_traffic_gen: RTL
====================

# bus_traffic_gen

Parametrised bus stimulus master that issues a programmable number of write beats (address, write data) over a valid/ready handshake. Address and data come from a seeded 32-bit LFSR. It replaces hand-written drive loops in the SV-fundamentals interface benches and sits between the bench control sequence and a bus interface instance, driving its master-side signals.

## Interface
- ADDR_W, 32, address width (1..32)
- DATA_W, 32, write-data width (8..32, multiple of 8)
- SEED, 32'h0000_0001, LFSR reset value; 0 is replaced by 1
- CNT_W, 16, width of transaction count
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a burst of num_txn beats (sampled in IDLE only)
- num_txn  input  CNT_W  beats to issue; latched on accepted start
- addr_mask  input  ADDR_W  AND-mask applied to every address; latched on start
- addr  output  ADDR_W  beat address
- wdata  output  DATA_W  beat write data
- valid  output  1  beat presented
- ready  input  1  sink accepts beat when valid && ready at posedge
- busy  output  1  high in DRIVE state
- done  output  1  one-cycle pulse at burst end
- txn_count  output  CNT_W  beats accepted in current/last burst

## Operation
- States: IDLE, DRIVE, FIN.
- IDLE: start=1 and num_txn>0 -> DRIVE; clear txn_count; latch num_txn, addr_mask. start=1 and num_txn=0 -> FIN (no beat issued).
- DRIVE: valid=1. On each accepted beat: txn_count+1, LFSR advances one step. If accepted beat is number num_txn -> FIN.
- FIN: done=1 for exactly one cycle -> IDLE.
- start outside IDLE ignored; num_txn/addr_mask changes after latch ignored.
- LFSR: 32-bit Galois, next = s[0] ? (s>>1) ^ 32'h8020_0003 : s>>1. Reset to SEED (1 if SEED=0). Not reseeded by start; continues across bursts.
- wdata = s[DATA_W-1:0]; addr = ({s[15:0], s[31:16]})[ADDR_W-1:0] & addr_mask (random mode).
- txn_count holds final value after done until next accepted start.

## Timing
- Reset (rst=1 at posedge): state IDLE, valid=0, busy=0, done=0, txn_count=0, addr=0, wdata=0, LFSR=SEED. Reset mid-burst: valid drops at that edge, no done pulse.
- Latency: start at edge N -> valid=1 and busy=1 after edge N; first beat visible in cycle N+1.
- Handshake: addr/wdata stable while valid && !ready; valid never drops without acceptance (except reset). Back-to-back accepts with ready held high: one beat per cycle.
- After last accept at edge M: valid=0, done=1 in cycle M+1; done=0, IDLE from cycle M+2. Earliest new start accepted at edge M+2.
- num_txn=0: done pulses cycle after start; valid never asserted.
- txn_count wraps never: max burst 2^CNT_W-1.

## Configuration
- BUS_TRAFFIC_GEN_INCR_EN defined: address mode is incrementing. addr=0 at burst start, next = (addr + DATA_W/8) & addr_mask per accepted beat (wraps inside mask); wdata still from LFSR.
- Undefined: random address mode as in Operation.

## Test plan
- Reset then idle: rst high 2 cycles -> valid=0, busy=0, done=0, txn_count=0, addr=0, wdata=0.
- SEED=1, addr_mask=32'hFF, num_txn=2, ready=1: beat0 addr=0x00 wdata=0x0000_0001; beat1 addr=0x20 wdata=0x8020_0003; done pulse cycle after beat1, txn_count=2.
- Backpressure: num_txn=1, ready low 3 cycles then high -> addr/wdata constant for 4 cycles, single accept, done once.
- num_txn=0 start -> done pulse next cycle, valid never high, txn_count=0; start during DRIVE ignored (burst length unchanged).
- Reset mid-burst: num_txn=5, rst after 2 accepts -> valid=0 next edge, no done, txn_count=0, LFSR back to SEED.
- BUS_TRAFFIC_GEN_INCR_EN, DATA_W=32, addr_mask=0x0F, num_txn=5, ready=1 -> addr sequence 0x0,0x4,0x8,0xC,0x0.

Source files
------------

// File: rtl/bus_traffic_gen.sv
// Bus stimulus master: issues num_txn write beats over valid/ready with LFSR data.
// Define BUS_TRAFFIC_GEN_INCR_EN for incrementing addresses; default is LFSR-random addresses.
module bus_traffic_gen #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter logic [31:0] SEED   = 32'h0000_0001,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_txn,
    input  logic [ADDR_W-1:0] addr_mask,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  txn_count
);

    // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_FIN   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [ADDR_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_inc;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef BUS_TRAFFIC_GEN_INCR_EN
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
    logic [ADDR_W-1:0] addr_q, addr_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_EFF;
            cnt_q   <= '0;
            num_q   <= '0;
            mask_q  <= '0;
`ifdef BUS_TRAFFIC_GEN_INCR_EN
            addr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            mask_q  <= mask_d;
`ifdef BUS_TRAFFIC_GEN_INCR_EN
            addr_q  <= addr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        mask_d  = mask_q;
`ifdef BUS_TRAFFIC_GEN_INCR_EN
        addr_d  = addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    num_d   = num_txn;
                    mask_d  = addr_mask;
`ifdef BUS_TRAFFIC_GEN_INCR_EN
                    addr_d  = '0;
`endif
                    state_d = (num_txn != '0) ? S_DRIVE : S_FIN;
                end
            end
            S_DRIVE: begin
                if (ready) begin
                    cnt_d  = cnt_inc;
                    lfsr_d = lfsr_step(lfsr_q);
`ifdef BUS_TRAFFIC_GEN_INCR_EN
                    addr_d = (addr_q + ADDR_STEP) & mask_q;
`endif
                    if (cnt_inc == num_q) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state; address/data read as zero between beats.
    logic [ADDR_W-1:0] beat_addr;

`ifdef BUS_TRAFFIC_GEN_INCR_EN
    assign beat_addr = addr_q;
`else
    logic [31:0] lfsr_swap;
    assign lfsr_swap = {lfsr_q[15:0], lfsr_q[31:16]};
    assign beat_addr = lfsr_swap[ADDR_W-1:0] & mask_q;
`endif

    assign valid     = (state_q == S_DRIVE);
    assign busy      = (state_q == S_DRIVE);
    assign done      = (state_q == S_FIN);
    assign txn_count = cnt_q;
    assign addr      = valid ? beat_addr : '0;
    assign wdata     = valid ? lfsr_q[DATA_W-1:0] : '0;

endmodule
